// File: rtl/ctrl_multicycle_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode/funct
// constants, and the ALU op, source-B, PC source and exception cause codes.
package ctrl_multicycle_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ, S_MEM_WB, S_MEM_WRITE,
        S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP, S_EXC
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010,
        ALU_OR  = 3'b011, ALU_SLT = 3'b100
    } alu_op_t;

    // Also decoded by the datapath's source-B mux.
    typedef enum logic [1:0] {
        SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_OFFSET = 2'b10, SRCB_IMM = 2'b11
    } srcb_t;

    typedef enum logic [1:0] {
        PCSRC_ALU = 2'b00, PCSRC_ALUOUT = 2'b01, PCSRC_JUMP = 2'b10, PCSRC_EXC = 2'b11
    } pc_src_t;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_OVF = 2'b10, CAUSE_BUS = 2'b11
    } cause_t;

endpackage

// File: rtl/ctrl_multicycle_alu_decode.sv
// R-type funct decoder: ALU operation, illegal-funct flag, and whether the
// operation is a signed add/sub that can overflow.
module ctrl_alu_decode
    import ctrl_multicycle_pkg::*;
(
    input  logic [5:0] funct,
    output alu_op_t    alu_op,
    output logic       illegal,
    output logic       addsub
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        addsub  = 1'b0;
        case (funct)
            FN_ADD: addsub = 1'b1;
            FN_SUB: begin alu_op = ALU_SUB; addsub = 1'b1; end
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_SLT: alu_op = ALU_SLT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_multicycle.sv
// Multicycle control FSM driving datapath muxes and write enables.
// Optional: define CTRL_OVERFLOW_EXC_EN to trap signed overflow on add/sub/addi.
module ctrl_multicycle
    import ctrl_multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic       alu_srcA,
    output logic [1:0] alu_srcB,
    output logic [2:0] alu_op,
    output logic       i_or_d,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       epc_write,
    output logic [1:0] cause
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state, state_n;
    cause_t     cause_q, cause_n;
    logic [7:0] wait_cnt;
    logic       mem_wait, timeout;
    alu_op_t    dec_op;
    logic       dec_illegal, dec_addsub;

    ctrl_alu_decode u_alu_dec (
        .funct   (funct),
        .alu_op  (dec_op),
        .illegal (dec_illegal),
        .addsub  (dec_addsub)
    );

    // zero gates the PC write in the datapath, not here.
    logic unused_in;
`ifdef CTRL_OVERFLOW_EXC_EN
    assign unused_in = zero;
`else
    assign unused_in = zero ^ overflow ^ dec_addsub;
`endif

    assign timeout = (wait_cnt == WAIT_LAST);
    assign cause   = cause_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_FETCH;
            cause_q  <= CAUSE_NONE;
            wait_cnt <= '0;
        end else begin
            state   <= state_n;
            cause_q <= cause_n;
            if (state_n != state)
                wait_cnt <= '0;
            else if (mem_wait && !mem_ready)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        state_n       = state;
        cause_n       = cause_q;
        mem_wait      = 1'b0;
        alu_srcA      = 1'b0;
        alu_srcB      = SRCB_REG;
        alu_op        = ALU_ADD;
        i_or_d        = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PCSRC_ALU;
        epc_write     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_rd   = 1'b1;
                alu_srcB = SRCB_FOUR;
                mem_wait = 1'b1;
                // Reset masks the completion so a fetch never lands mid-reset.
                if (mem_ready) begin
                    ir_write = reset;
                    pc_write = reset;
                    state_n  = S_DECODE;
                end else if (timeout) begin
                    state_n = S_EXC;
                    cause_n = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                alu_srcB = SRCB_OFFSET;
                case (opcode)
                    OP_RTYPE: state_n = dec_illegal ? S_EXC : S_R_EXEC;
                    OP_LW, OP_SW: state_n = S_MEM_ADDR;
                    OP_BEQ:  state_n = S_BRANCH;
                    OP_J:    state_n = S_JUMP;
                    OP_ADDI: state_n = S_I_EXEC;
                    default: state_n = S_EXC;
                endcase
                if (state_n == S_EXC) cause_n = CAUSE_ILLEGAL;
            end
            S_MEM_ADDR: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_IMM;
                state_n  = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ, S_MEM_WRITE: begin
                i_or_d   = 1'b1;
                mem_rd   = (state == S_MEM_READ);
                mem_wr   = (state == S_MEM_WRITE);
                mem_wait = 1'b1;
                if (mem_ready) begin
                    state_n = (state == S_MEM_READ) ? S_MEM_WB : S_FETCH;
                end else if (timeout) begin
                    state_n = S_EXC;
                    cause_n = CAUSE_BUS;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_n    = S_FETCH;
            end
            S_R_EXEC: begin
                alu_srcA = 1'b1;
                alu_op   = dec_op;
                state_n  = S_R_WB;
`ifdef CTRL_OVERFLOW_EXC_EN
                if (overflow && dec_addsub) begin
                    state_n = S_EXC;
                    cause_n = CAUSE_OVF;
                end
`endif
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_n   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_srcA = 1'b1;
                alu_srcB = SRCB_IMM;
                state_n  = S_I_WB;
`ifdef CTRL_OVERFLOW_EXC_EN
                if (overflow) begin
                    state_n = S_EXC;
                    cause_n = CAUSE_OVF;
                end
`endif
            end
            S_I_WB: begin
                reg_write = 1'b1;
                state_n   = S_FETCH;
            end
            S_BRANCH: begin
                alu_srcA      = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PCSRC_ALUOUT;
                state_n       = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PCSRC_JUMP;
                state_n  = S_FETCH;
            end
            S_EXC: begin
                epc_write = 1'b1;
                pc_write  = 1'b1;
                pc_src    = PCSRC_EXC;
                state_n   = S_FETCH;
            end
            default: state_n = S_FETCH;
        endcase
    end

endmodule
